// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared constants and FSM state type for the instruction-memory loader
// Purpose: frame sync byte, instruction word width and loader FSM encoding.
// Ports: none (package).
package imem_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         WORD_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_DATA_LO = 3'd4,
    ST_CHECK   = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERR     = 3'd7
  } state_t;

endpackage

// File: rtl/loader_timeout.sv
// rtl/loader_timeout.sv - inter-byte idle timer for the loader
// Purpose: counts enabled cycles; expires on the TIMEOUT-th consecutive enabled cycle.
// Ports:
//   i_clk      system clock
//   i_clear    synchronous active-high reset
//   i_restart  zero the count (handshake seen, or loader not inside a frame)
//   i_en       count this cycle
//   o_expire   high during the cycle whose closing edge completes TIMEOUT idle cycles
module loader_timeout #(
  parameter int TIMEOUT = 1000
) (
  input  logic i_clk,
  input  logic i_clear,
  input  logic i_restart,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  // Expire is flagged one count early so the FSM leaves on exactly the TIMEOUT-th idle edge.
  assign o_expire = i_en && (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_clear || i_restart) begin
      r_cnt <= '0;
    end else if (i_en && !o_expire) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader writing 16-bit words into instruction memory
// Purpose: parses A5 | LEN_HI | LEN_LO | words (hi,lo) | CSUM, writes each word, releases
//   the MCU only after a frame with a good mod-256 payload checksum.
// Ports:
//   i_clk, i_clear      clock, synchronous active-high reset
//   i_rx_data/valid     incoming byte link; o_rx_ready accepts
//   o_im_we/addr/wdata  instruction-memory write port, one strobe cycle per word
//   o_cpu_run           1 releases the MCU from clear
//   o_done, o_error     outcome of the last frame
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic              i_clk,
  input  logic              i_clear,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic              o_im_we,
  output logic [ADDR_W-1:0] o_im_addr,
  output logic [WORD_W-1:0] o_im_wdata,
  output logic              o_cpu_run,
  output logic              o_done,
  output logic              o_error
);

  state_t r_state, w_state_nxt;

  logic              r_rx_ready;
  logic [7:0]        r_len_hi;
  logic [15:0]       r_len;
  logic [ADDR_W:0]   r_ctr;      // one extra bit so a full 2**ADDR_W image can be counted
  logic [7:0]        r_hi;
  logic [7:0]        r_csum;
  logic              r_im_we;
  logic [ADDR_W-1:0] r_im_addr;
  logic [WORD_W-1:0] r_im_wdata;

  logic        w_hs;
  logic [15:0] w_len;
  logic        w_len_too_big;
  logic        w_last;
  logic        w_timer_active;
  logic        w_expire;

  assign w_hs          = i_rx_valid & r_rx_ready;
  assign w_len         = {r_len_hi, i_rx_data};
  assign w_len_too_big = 64'(w_len) > (64'd1 << ADDR_W);
  assign w_last        = (64'(r_ctr) + 64'd1) == 64'(r_len);

  assign w_timer_active = (r_state == ST_LEN_HI) || (r_state == ST_LEN_LO) ||
                          (r_state == ST_DATA_HI) || (r_state == ST_DATA_LO) ||
                          (r_state == ST_CHECK);

  loader_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_clear   (i_clear),
    .i_restart (w_hs || !w_timer_active),
    .i_en      (w_timer_active && !w_hs),
    .o_expire  (w_expire)
  );

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_expire) begin
      w_state_nxt = ST_ERR;
    end else if (w_hs) begin
      case (r_state)
        ST_IDLE:    if (i_rx_data == SYNC_BYTE) w_state_nxt = ST_LEN_HI;
        ST_LEN_HI:  w_state_nxt = ST_LEN_LO;
        ST_LEN_LO: begin
          if (w_len_too_big)    w_state_nxt = ST_ERR;
          else if (w_len == '0) w_state_nxt = ST_CHECK;
          else                  w_state_nxt = ST_DATA_HI;
        end
        ST_DATA_HI: w_state_nxt = ST_DATA_LO;
        ST_DATA_LO: w_state_nxt = w_last ? ST_CHECK : ST_DATA_HI;
        ST_CHECK:   w_state_nxt = (i_rx_data == r_csum) ? ST_DONE : ST_ERR;
        ST_DONE,
        ST_ERR:     if (i_rx_data == SYNC_BYTE) w_state_nxt = ST_LEN_HI;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_rx_ready <= 1'b0;
      r_len_hi   <= '0;
      r_len      <= '0;
      r_ctr      <= '0;
      r_hi       <= '0;
      r_csum     <= '0;
      r_im_we    <= 1'b0;
      r_im_addr  <= '0;
      r_im_wdata <= '0;
    end else begin
      r_rx_ready <= 1'b1;
      r_im_we    <= 1'b0;
      if (w_hs) begin
        case (r_state)
          ST_LEN_HI: r_len_hi <= i_rx_data;
          ST_LEN_LO: begin
            r_len  <= w_len;
            r_ctr  <= '0;
            r_csum <= '0;
          end
          ST_DATA_HI: begin
            r_hi   <= i_rx_data;
            r_csum <= r_csum + i_rx_data;
          end
          ST_DATA_LO: begin
            r_im_we    <= 1'b1;
            r_im_addr  <= r_ctr[ADDR_W-1:0];
            r_im_wdata <= {r_hi, i_rx_data};
            r_ctr      <= r_ctr + 1'b1;
            r_csum     <= r_csum + i_rx_data;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_rx_ready = r_rx_ready;
  assign o_im_we    = r_im_we;
  assign o_im_addr  = r_im_addr;
  assign o_im_wdata = r_im_wdata;
  assign o_done     = (r_state == ST_DONE);
  assign o_cpu_run  = (r_state == ST_DONE);
  assign o_error    = (r_state == ST_ERR);

endmodule
